// File: rtl/jzjpcc_immediate_stage.sv
// Immediate generator plus decode->execute register: I/S/B/U/J/Zicsr-uimm extraction, XLEN sign-extension, PC-relative target.
// Latency: 1 cycle. No combinational path from any input to any output.
// Backpressure: stall holds every output, flush clears the register and wins over stall. There is no ready handshake.
// Ports: clock/reset_n; instruction_decode, pc_decode, valid_decode in; stall, flush control;
//        valid/immediate/imm_type/target/illegal _execute registered out.
module jzjpcc_immediate_stage #(
  parameter int XLEN          = 32,
  parameter bit SUPPORT_ZICSR = 1'b1,
  parameter bit SUPPORT_RV64I = 1'b0
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [31:0]     instruction_decode,
  input  logic [XLEN-1:0] pc_decode,
  input  logic            valid_decode,
  input  logic            stall,
  input  logic            flush,
  output logic            valid_execute,
  output logic [XLEN-1:0] immediate_execute,
  output logic [2:0]      imm_type_execute,
  output logic [XLEN-1:0] target_execute,
  output logic            illegal_execute
);

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;
  localparam logic [2:0] T_Z    = 3'd6;

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("jzjpcc_immediate_stage: XLEN must be 32 or 64");
  end
  if (SUPPORT_RV64I && XLEN != 64) begin : g_bad_rv64i
    $error("jzjpcc_immediate_stage: SUPPORT_RV64I requires XLEN=64");
  end

  logic [31:0] inst;
  logic [4:0]  opcode;
  assign inst   = instruction_decode;
  assign opcode = inst[6:2];

  // Only funct3[2] matters here; funct3[1:0] are consumed by execute.
  logic unused_funct3_low;
  assign unused_funct3_low = ^inst[13:12];

  logic [2:0]         type_d;
  logic               illegal_d;
  logic               use_pc_d;
  logic signed [31:0] raw_imm;
  logic [XLEN-1:0]    imm_d;
  logic [XLEN-1:0]    target_d;

  always_comb begin
    type_d    = T_NONE;
    illegal_d = 1'b0;
    use_pc_d  = 1'b0;
    unique case (opcode)
      5'b00000, 5'b00100, 5'b11001: type_d = T_I;
      5'b00110: begin
        if (SUPPORT_RV64I) type_d = T_I;
        else               illegal_d = 1'b1;
      end
      5'b01000: type_d = T_S;
      5'b11000: begin type_d = T_B; use_pc_d = 1'b1; end
      5'b11011: begin type_d = T_J; use_pc_d = 1'b1; end
      5'b01101: type_d = T_U;
      5'b00101: begin type_d = T_U; use_pc_d = 1'b1; end
      5'b11100: begin
        if (SUPPORT_ZICSR && inst[14]) type_d = T_Z;
      end
      5'b01100, 5'b00011: type_d = T_NONE;
      5'b01110: begin
        if (!SUPPORT_RV64I) illegal_d = 1'b1;
      end
      default: illegal_d = 1'b1;
    endcase
    // A non-32-bit encoding overrides whatever the opcode looked like.
    if (inst[1:0] != 2'b11) begin
      illegal_d = 1'b1;
      type_d    = T_NONE;
      use_pc_d  = 1'b0;
    end
  end

  // Every format is built as a signed 32-bit value first, then a single
  // sign-extending cast widens it. For RV64 this makes LUI/AUIPC sign-extend too.
  always_comb begin
    raw_imm = '0;
    unique case (type_d)
      T_I: raw_imm = {{20{inst[31]}}, inst[31:20]};
      T_S: raw_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      T_B: raw_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      T_U: raw_imm = {inst[31:12], 12'b0};
      T_J: raw_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      T_Z: raw_imm = {27'b0, inst[19:15]};
      default: raw_imm = '0;
    endcase
    imm_d    = XLEN'(raw_imm);
    target_d = use_pc_d ? (pc_decode + imm_d) : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_execute     <= 1'b0;
      immediate_execute <= '0;
      imm_type_execute  <= T_NONE;
      target_execute    <= '0;
      illegal_execute   <= 1'b0;
    end else if (flush) begin
      valid_execute     <= 1'b0;
      immediate_execute <= '0;
      imm_type_execute  <= T_NONE;
      target_execute    <= '0;
      illegal_execute   <= 1'b0;
    end else if (stall) begin
      valid_execute     <= valid_execute;
    end else if (valid_decode) begin
      valid_execute     <= 1'b1;
      immediate_execute <= imm_d;
      imm_type_execute  <= type_d;
      target_execute    <= target_d;
      illegal_execute   <= illegal_d;
    end else begin
      // A bubble clears valid only; the data fields keep their last value.
      valid_execute     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jzjpcc_immediate_stage.sv
module tb_jzjpcc_immediate_stage;

  logic        clock;
  logic        reset_n;
  logic [31:0] instruction_decode;
  logic [63:0] pc64;
  logic [31:0] pc32;
  logic        valid_decode;
  logic        stall;
  logic        flush;

  logic        v64, ill64, v32, ill32, vn, illn;
  logic [63:0] imm64, tgt64;
  logic [31:0] imm32, tgt32, immn, tgtn;
  logic [2:0]  ty64, ty32, tyn;

  int n_checks = 0;
  int n_fail   = 0;

  jzjpcc_immediate_stage #(.XLEN(64), .SUPPORT_ZICSR(1'b1), .SUPPORT_RV64I(1'b1)) u64 (
    .clock(clock), .reset_n(reset_n), .instruction_decode(instruction_decode),
    .pc_decode(pc64), .valid_decode(valid_decode), .stall(stall), .flush(flush),
    .valid_execute(v64), .immediate_execute(imm64), .imm_type_execute(ty64),
    .target_execute(tgt64), .illegal_execute(ill64));

  jzjpcc_immediate_stage #(.XLEN(32), .SUPPORT_ZICSR(1'b1), .SUPPORT_RV64I(1'b0)) u32 (
    .clock(clock), .reset_n(reset_n), .instruction_decode(instruction_decode),
    .pc_decode(pc32), .valid_decode(valid_decode), .stall(stall), .flush(flush),
    .valid_execute(v32), .immediate_execute(imm32), .imm_type_execute(ty32),
    .target_execute(tgt32), .illegal_execute(ill32));

  jzjpcc_immediate_stage #(.XLEN(32), .SUPPORT_ZICSR(1'b0), .SUPPORT_RV64I(1'b0)) u32n (
    .clock(clock), .reset_n(reset_n), .instruction_decode(instruction_decode),
    .pc_decode(pc32), .valid_decode(valid_decode), .stall(stall), .flush(flush),
    .valid_execute(vn), .immediate_execute(immn), .imm_type_execute(tyn),
    .target_execute(tgtn), .illegal_execute(illn));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the capturing edge.
  task automatic cyc(input logic [31:0] ins, input logic [63:0] pc,
                     input logic vld, input logic stl, input logic fl);
    instruction_decode = ins;
    pc64         = pc;
    pc32         = pc[31:0];
    valid_decode = vld;
    stall        = stl;
    flush        = fl;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    instruction_decode = '0;
    pc64 = '0; pc32 = '0;
    valid_decode = 1'b0; stall = 1'b0; flush = 1'b0;
    #3;
    check("rst_valid64", {63'b0, v64}, 64'd0);
    check("rst_imm64",   imm64, 64'd0);
    check("rst_tgt32",   {32'b0, tgt32}, 64'd0);
    check("rst_type32",  {61'b0, ty32}, 64'd0);
    #4 reset_n = 1'b1;

    // ADDI x1,x0,-1
    cyc(32'hFFF00093, 64'h0, 1'b1, 1'b0, 1'b0);
    check("addi_imm64",   imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_type64",  {61'b0, ty64}, 64'd1);
    check("addi_valid64", {63'b0, v64}, 64'd1);
    check("addi_tgt64",   tgt64, 64'd0);
    check("addi_imm32",   {32'b0, imm32}, 64'hFFFF_FFFF);

    // Asynchronous reset asserted mid-cycle must clear outputs before the next edge.
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid64", {63'b0, v64}, 64'd0);
    check("arst_imm64",   imm64, 64'd0);
    check("arst_type64",  {61'b0, ty64}, 64'd0);
    #2 reset_n = 1'b1;

    // Bubble: valid drops, data holds.
    cyc(32'hFFF00093, 64'h0, 1'b1, 1'b0, 1'b0);
    cyc(32'h00000000, 64'h0, 1'b0, 1'b0, 1'b0);
    check("bubble_valid64", {63'b0, v64}, 64'd0);
    check("bubble_imm64",   imm64, 64'hFFFF_FFFF_FFFF_FFFF);

    // BEQ offset -4
    cyc(32'hFE000EE3, 64'h4, 1'b1, 1'b0, 1'b0);
    check("beq_imm32",  {32'b0, imm32}, 64'hFFFF_FFFC);
    check("beq_type32", {61'b0, ty32}, 64'd3);
    check("beq_tgt32",  {32'b0, tgt32}, 64'd0);
    check("beq_tgt64",  tgt64, 64'd0);
    cyc(32'hFE000EE3, 64'h0, 1'b1, 1'b0, 1'b0);
    check("beq_wrap32", {32'b0, tgt32}, 64'hFFFF_FFFC);
    check("beq_wrap64", tgt64, 64'hFFFF_FFFF_FFFF_FFFC);

    // LUI 0x80000
    cyc(32'h800000B7, 64'h1234, 1'b1, 1'b0, 1'b0);
    check("lui_imm32",  {32'b0, imm32}, 64'h8000_0000);
    check("lui_imm64",  imm64, 64'hFFFF_FFFF_8000_0000);
    check("lui_type64", {61'b0, ty64}, 64'd4);
    check("lui_tgt64",  tgt64, 64'd0);

    // AUIPC x1,1 uses the PC
    cyc(32'h00001097, 64'h100, 1'b1, 1'b0, 1'b0);
    check("auipc_imm32", {32'b0, imm32}, 64'h1000);
    check("auipc_tgt32", {32'b0, tgt32}, 64'h1100);

    // SW x1,-8(x2): S-type split field
    cyc(32'hFE112C23, 64'h0, 1'b1, 1'b0, 1'b0);
    check("sw_imm32",  {32'b0, imm32}, 64'hFFFF_FFF8);
    check("sw_type32", {61'b0, ty32}, 64'd2);

    // CSRRWI uimm=31
    cyc(32'h340FD073, 64'h0, 1'b1, 1'b0, 1'b0);
    check("csr_imm32",   {32'b0, imm32}, 64'h1F);
    check("csr_type32",  {61'b0, ty32}, 64'd6);
    check("csr_typeNZ",  {61'b0, tyn}, 64'd0);
    check("csr_illNZ",   {63'b0, illn}, 64'd0);
    check("csr_immNZ",   {32'b0, immn}, 64'd0);

    // All-zero word: illegal (inst[1:0]=00)
    cyc(32'h00000000, 64'h40, 1'b1, 1'b0, 1'b0);
    check("zero_ill32",  {63'b0, ill32}, 64'd1);
    check("zero_imm32",  {32'b0, imm32}, 64'd0);
    check("zero_type32", {61'b0, ty32}, 64'd0);

    // ADD: legal, no immediate
    cyc(32'h00000033, 64'h0, 1'b1, 1'b0, 1'b0);
    check("add_ill32", {63'b0, ill32}, 64'd0);

    // ADDIW: I-type on RV64I, illegal on RV32
    cyc(32'hFFF0009B, 64'h0, 1'b1, 1'b0, 1'b0);
    check("addiw_type64", {61'b0, ty64}, 64'd1);
    check("addiw_imm64",  imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addiw_ill32",  {63'b0, ill32}, 64'd1);
    check("addiw_imm32",  {32'b0, imm32}, 64'd0);

    // JAL x1,8 then stall with a different instruction presented
    cyc(32'h008000EF, 64'h1000, 1'b1, 1'b0, 1'b0);
    check("jal_imm32",  {32'b0, imm32}, 64'h8);
    check("jal_type32", {61'b0, ty32}, 64'd5);
    check("jal_tgt32",  {32'b0, tgt32}, 64'h1008);
    for (int k = 0; k < 3; k++) begin
      cyc(32'hFFF00093, 64'h2000, 1'b1, 1'b1, 1'b0);
      check("stall_imm32",   {32'b0, imm32}, 64'h8);
      check("stall_tgt32",   {32'b0, tgt32}, 64'h1008);
      check("stall_type32",  {61'b0, ty32}, 64'd5);
      check("stall_valid32", {63'b0, v32}, 64'd1);
    end
    cyc(32'hFFF00093, 64'h2000, 1'b1, 1'b1, 1'b1);
    check("flush_valid32", {63'b0, v32}, 64'd0);
    check("flush_imm32",   {32'b0, imm32}, 64'd0);
    check("flush_tgt32",   {32'b0, tgt32}, 64'd0);
    check("flush_type32",  {61'b0, ty32}, 64'd0);
    check("flush_imm64",   imm64, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
